// File: rtl/fir_mac_scheduler.sv
// Round-robin sequencer for the shared FIR MAC datapath (delay-line/coeff BRAM + MAC).
// Define FIR_SCHED_OVERRUN_EN to enable per-channel sticky overrun detection.

`ifdef FIR_SCHED_OVERRUN_EN
module fir_sched_wait_cnt #(
    parameter int MAX_WAIT = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic req,
    input  logic ack,
    output logic overrun
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            if (ack)
                cnt <= '0;
            else if (req && cnt != CW'(MAX_WAIT))
                cnt <= cnt + 1'b1;
            if (cnt == CW'(MAX_WAIT))
                overrun <= 1'b1;
        end
    end
endmodule
`endif

module fir_mac_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int TAP_COUNT   = 65,
    parameter int CH_COUNT    = 2,
    parameter int MEM_LATENCY = 2,
    parameter int MAC_LATENCY = 3,
    parameter int MAX_WAIT    = 256,
    localparam int LEN = $clog2(TAP_COUNT),
    localparam int CHW = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CH_COUNT-1:0] i_req,
    output logic [CH_COUNT-1:0] o_ack,
    output logic                o_busy,
    output logic [CHW-1:0]      o_ch,
    output logic                o_dl_wren,
    output logic [LEN-1:0]      o_dl_wr_addr,
    output logic                o_mem_rden,
    output logic [LEN-1:0]      o_dl_rd_addr,
    output logic [LEN-1:0]      o_coeff_addr,
    output logic                o_acc_clr,
    output logic                o_mac_en,
    output logic                o_result_valid,
    output logic [CHW-1:0]      o_result_ch,
    output logic [CH_COUNT-1:0] o_overrun
);
    localparam int DRAIN_N = MEM_LATENCY + MAC_LATENCY;
    localparam int DW      = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_WRITE, S_ISSUE, S_DRAIN, S_DONE
    } state_t;

    state_t                       state;
    logic [CHW-1:0]               prio;
    logic [CH_COUNT-1:0][LEN-1:0] wr_ptr;
    logic [DW-1:0]                drain_cnt;
    logic [MEM_LATENCY:1]         vld_pipe;

    logic [CHW-1:0]      rr_idx;
    logic [CHW-1:0]      gnt_ch;
    logic [CH_COUNT-1:0] gnt_oh;
    logic [CHW-1:0]      prio_nxt;
    logic [LEN-1:0]      cur_ptr;
    logic [LEN-1:0]      nxt_ptr;
    logic [LEN-1:0]      rd_nxt;

    // Scan downwards so the lowest offset from the priority pointer wins.
    always_comb begin
        rr_idx = '0;
        gnt_ch = '0;
        gnt_oh = '0;
        for (int i = CH_COUNT - 1; i >= 0; i--) begin
            rr_idx = CHW'((int'(prio) + i) % CH_COUNT);
            if (i_req[rr_idx])
                gnt_ch = rr_idx;
        end
        gnt_oh[gnt_ch] = 1'b1;
    end

    assign prio_nxt = (gnt_ch == CHW'(CH_COUNT - 1)) ? '0 : gnt_ch + 1'b1;
    assign cur_ptr  = wr_ptr[o_ch];
    assign nxt_ptr  = (cur_ptr == '0) ? LEN'(TAP_COUNT - 1) : cur_ptr - 1'b1;
    assign rd_nxt   = (o_dl_rd_addr == LEN'(TAP_COUNT - 1)) ? '0 : o_dl_rd_addr + 1'b1;

    assign o_mac_en    = vld_pipe[MEM_LATENCY];
    assign o_result_ch = o_ch;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            prio           <= '0;
            wr_ptr         <= '0;
            drain_cnt      <= '0;
            vld_pipe       <= '0;
            o_ack          <= '0;
            o_busy         <= 1'b0;
            o_ch           <= '0;
            o_dl_wren      <= 1'b0;
            o_dl_wr_addr   <= '0;
            o_mem_rden     <= 1'b0;
            o_dl_rd_addr   <= '0;
            o_coeff_addr   <= '0;
            o_acc_clr      <= 1'b0;
            o_result_valid <= 1'b0;
        end else begin
            o_ack          <= '0;
            o_dl_wren      <= 1'b0;
            o_acc_clr      <= 1'b0;
            o_mem_rden     <= 1'b0;
            o_result_valid <= 1'b0;

            // Read data reaches the MAC MEM_LATENCY cycles after the strobe.
            vld_pipe[1] <= o_mem_rden;
            for (int i = MEM_LATENCY; i > 1; i--)
                vld_pipe[i] <= vld_pipe[i-1];

            case (state)
                S_IDLE: begin
                    if (|i_req) begin
                        state  <= S_ARB;
                        o_ack  <= gnt_oh;
                        o_ch   <= gnt_ch;
                        o_busy <= 1'b1;
                        prio   <= prio_nxt;
                    end
                end
                S_ARB: begin
                    state        <= S_WRITE;
                    wr_ptr[o_ch] <= nxt_ptr;
                    o_dl_wren    <= 1'b1;
                    o_dl_wr_addr <= nxt_ptr;
                    o_acc_clr    <= 1'b1;
                end
                S_WRITE: begin
                    // Tap 0 reads back the sample written in the previous cycle.
                    state        <= S_ISSUE;
                    o_mem_rden   <= 1'b1;
                    o_coeff_addr <= '0;
                    o_dl_rd_addr <= cur_ptr;
                end
                S_ISSUE: begin
                    if (o_coeff_addr == LEN'(TAP_COUNT - 1)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        o_mem_rden   <= 1'b1;
                        o_coeff_addr <= o_coeff_addr + 1'b1;
                        o_dl_rd_addr <= rd_nxt;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_N - 1)) begin
                        state          <= S_DONE;
                        o_result_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FIR_SCHED_OVERRUN_EN
    for (genvar c = 0; c < CH_COUNT; c++) begin : g_wait
        fir_sched_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .req     (i_req[c]),
            .ack     (o_ack[c]),
            .overrun (o_overrun[c])
        );
    end
`else
    assign o_overrun = '0;
`endif

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler: expected result channels queued at stimulus time.
module tb_fir_mac_scheduler;
    localparam int TAPS     = 65;
    localparam int CH       = 3;
    localparam int MEM_LAT  = 2;
    localparam int MAC_LAT  = 3;
    localparam int MW       = 50;
    localparam int LEN      = 7;
    localparam int CHW      = 2;
    localparam int PASS_LEN = TAPS + MEM_LAT + MAC_LAT + 2;
    localparam int AW       = 2*CH + 3*LEN + 2*CHW + 6;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [CH-1:0]  i_req = '0;
    logic [CH-1:0]  o_ack, o_overrun;
    logic           o_busy, o_dl_wren, o_mem_rden, o_acc_clr, o_mac_en, o_result_valid;
    logic [CHW-1:0] o_ch, o_result_ch;
    logic [LEN-1:0] o_dl_wr_addr, o_dl_rd_addr, o_coeff_addr;
    logic [AW-1:0]  all_outs;

    fir_mac_scheduler #(
        .DATA_WIDTH(16), .TAP_COUNT(TAPS), .CH_COUNT(CH),
        .MEM_LATENCY(MEM_LAT), .MAC_LATENCY(MAC_LAT), .MAX_WAIT(MW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_ack(o_ack), .o_busy(o_busy),
        .o_ch(o_ch), .o_dl_wren(o_dl_wren), .o_dl_wr_addr(o_dl_wr_addr),
        .o_mem_rden(o_mem_rden), .o_dl_rd_addr(o_dl_rd_addr), .o_coeff_addr(o_coeff_addr),
        .o_acc_clr(o_acc_clr), .o_mac_en(o_mac_en), .o_result_valid(o_result_valid),
        .o_result_ch(o_result_ch), .o_overrun(o_overrun)
    );

    assign all_outs = {o_ack, o_busy, o_ch, o_dl_wren, o_dl_wr_addr, o_mem_rden, o_dl_rd_addr,
                       o_coeff_addr, o_acc_clr, o_mac_en, o_result_valid, o_result_ch, o_overrun};

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ack_ch[$], ack_cyc[$], wr_addr[$], wr_cyc[$];
    int rd_addr[$], cf_addr[$], rd_cyc[$], mac_cyc[$], res_ch[$], res_cyc[$];
    int exp_q[$];
    int model_ptr[CH];
    int busy_n;
    bit auto_drop;
    bit wto;

    function automatic int next_ptr(input int p);
        return (p == 0) ? TAPS - 1 : p - 1;
    endfunction

    task automatic clear_logs();
        ack_ch.delete(); ack_cyc.delete(); wr_addr.delete(); wr_cyc.delete();
        rd_addr.delete(); cf_addr.delete(); rd_cyc.delete(); mac_cyc.delete();
        res_ch.delete(); res_cyc.delete();
        busy_n = 0;
    endtask

    task automatic reset_dut();
        i_rst = 1'b1;
        i_req = '0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        for (int c = 0; c < CH; c++) model_ptr[c] = 0;
        exp_q.delete();
    endtask

    // Step cycles, logging DUT activity; stops once n_res results are seen.
    task automatic watch(input int n_res, input int max_cyc);
        wto = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge i_clk);
            for (int c = 0; c < CH; c++) begin
                if (o_ack[c]) begin
                    ack_ch.push_back(c);
                    ack_cyc.push_back(cyc);
                    if (auto_drop) i_req[c] = 1'b0;
                end
            end
            if (o_dl_wren) begin
                wr_addr.push_back(int'(o_dl_wr_addr));
                wr_cyc.push_back(cyc);
            end
            if (o_mem_rden) begin
                rd_addr.push_back(int'(o_dl_rd_addr));
                cf_addr.push_back(int'(o_coeff_addr));
                rd_cyc.push_back(cyc);
            end
            if (o_mac_en) mac_cyc.push_back(cyc);
            if (o_result_valid) begin
                res_ch.push_back(int'(o_result_ch));
                res_cyc.push_back(cyc);
            end
            if (o_busy) busy_n++;
            if (n_res > 0 && res_ch.size() >= n_res) return;
        end
        if (n_res > 0) wto = 1'b1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_req = '1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", all_outs);
        end
        i_req = '0;
        i_rst = 1'b0;
        for (int c = 0; c < CH; c++) model_ptr[c] = 0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_ack !== '0) begin
            errors++; $display("FAIL reset_idle busy %b ack %b want 0 0", o_busy, o_ack);
        end
    endtask

    task automatic test_single_pass();
        int exp_wr, e;
        clear_logs();
        auto_drop = 1'b1;
        i_req = 3'b001;
        exp_q.push_back(0);
        exp_wr = next_ptr(model_ptr[0]);
        model_ptr[0] = exp_wr;
        watch(1, PASS_LEN + 20);
        checks++;
        if (wto) begin errors++; $display("FAIL single_timeout no result within budget"); end
        watch(0, 5);
        checks++;
        if (ack_ch.size() != 1 || ack_ch[0] != 0) begin
            errors++; $display("FAIL single_ack count %0d want 1 on ch 0", ack_ch.size());
        end
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] != exp_wr || wr_cyc[0] != ack_cyc[0] + 1) begin
            errors++; $display("FAIL single_write n %0d addr %0d want 1 x %0d", wr_addr.size(),
                               (wr_addr.size() > 0) ? wr_addr[0] : -1, exp_wr);
        end
        checks++;
        if (rd_addr.size() != TAPS) begin
            errors++; $display("FAIL single_rd_count got %0d want %0d", rd_addr.size(), TAPS);
        end
        for (int k = 0; k < rd_addr.size() && k < TAPS; k++) begin
            checks++;
            if (cf_addr[k] != k || rd_addr[k] != (exp_wr + k) % TAPS) begin
                errors++; $display("FAIL single_tap%0d coeff %0d rd %0d want %0d %0d",
                                   k, cf_addr[k], rd_addr[k], k, (exp_wr + k) % TAPS);
            end
        end
        checks++;
        if (rd_cyc.size() == 0 || rd_cyc[0] != ack_cyc[0] + 2) begin
            errors++; $display("FAIL single_first_read not 2 cycles after ack");
        end
        checks++;
        if (mac_cyc.size() != TAPS || mac_cyc[0] != rd_cyc[0] + MEM_LAT ||
            mac_cyc[mac_cyc.size()-1] != mac_cyc[0] + TAPS - 1) begin
            errors++; $display("FAIL single_mac_en count %0d want %0d contiguous after %0d cycles",
                               mac_cyc.size(), TAPS, MEM_LAT);
        end
        checks++;
        if (busy_n != PASS_LEN + 1) begin
            errors++; $display("FAIL single_busy cycles %0d want %0d", busy_n, PASS_LEN + 1);
        end
        checks++;
        if (res_ch.size() != 1) begin
            errors++; $display("FAIL single_results got %0d want 1", res_ch.size());
        end
        for (int i = 0; i < res_ch.size(); i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_unexpected result ch %0d", res_ch[i]);
            end else begin
                e = exp_q.pop_front();
                if (res_ch[i] != e || res_cyc[i] != ack_cyc[0] + PASS_LEN) begin
                    errors++; $display("FAIL single_result ch %0d at +%0d want ch %0d at +%0d",
                                       res_ch[i], res_cyc[i] - ack_cyc[0], e, PASS_LEN);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int exp_wr, e, mx;
        reset_dut();
        auto_drop = 1'b1;
        for (int p = 0; p < TAPS + 1; p++) begin
            clear_logs();
            i_req = 3'b001;
            exp_q.push_back(0);
            exp_wr = next_ptr(model_ptr[0]);
            model_ptr[0] = exp_wr;
            watch(1, PASS_LEN + 20);
            checks++;
            if (wto || wr_addr.size() != 1 || wr_addr[0] != exp_wr) begin
                errors++; $display("FAIL wrap_wr pass %0d got %0d want %0d", p,
                                   (wr_addr.size() > 0) ? wr_addr[0] : -1, exp_wr);
            end
            checks++;
            if (rd_addr.size() == 0 || rd_addr[0] != exp_wr) begin
                errors++; $display("FAIL wrap_first_rd pass %0d want %0d", p, exp_wr);
            end
            mx = 0;
            foreach (rd_addr[i]) if (rd_addr[i] > mx) mx = rd_addr[i];
            checks++;
            if (mx > TAPS - 1) begin
                errors++; $display("FAIL wrap_rd_max pass %0d got %0d want <= %0d", p, mx, TAPS - 1);
            end
            for (int i = 0; i < res_ch.size(); i++) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb_unexpected result ch %0d", res_ch[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (res_ch[i] != e) begin
                        errors++; $display("FAIL wrap_result_ch got %0d want %0d", res_ch[i], e);
                    end
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int e, exp_wr;
        reset_dut();
        clear_logs();
        auto_drop = 1'b0;
        i_req = '1;
        for (int i = 0; i < 6; i++) exp_q.push_back(i % CH);
        watch(6, 6 * (PASS_LEN + 2) + 20);
        i_req = '0;
        watch(0, 4);
        checks++;
        if (wto || ack_ch.size() != 6) begin
            errors++; $display("FAIL rr_count acks %0d want 6", ack_ch.size());
        end
        for (int i = 0; i < ack_ch.size() && i < 6; i++) begin
            checks++;
            exp_wr = next_ptr(model_ptr[i % CH]);
            model_ptr[i % CH] = exp_wr;
            if (ack_ch[i] != i % CH || wr_addr.size() <= i || wr_addr[i] != exp_wr) begin
                errors++; $display("FAIL rr_grant%0d ch %0d want ch %0d wr %0d", i, ack_ch[i], i % CH, exp_wr);
            end
            if (i > 0) begin
                checks++;
                if (ack_cyc[i] - ack_cyc[i-1] != PASS_LEN + 2) begin
                    errors++; $display("FAIL rr_spacing%0d got %0d want %0d", i,
                                       ack_cyc[i] - ack_cyc[i-1], PASS_LEN + 2);
                end
            end
        end
        for (int i = 0; i < res_ch.size(); i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_unexpected result ch %0d", res_ch[i]);
            end else begin
                e = exp_q.pop_front();
                if (res_ch[i] != e) begin
                    errors++; $display("FAIL rr_result%0d ch %0d want %0d", i, res_ch[i], e);
                end
            end
        end
    endtask

    task automatic test_late_request();
        int e, w0, w1;
        clear_logs();
        auto_drop = 1'b1;
        i_req = 3'b001;
        exp_q.push_back(0);
        w0 = next_ptr(model_ptr[0]); model_ptr[0] = w0;
        watch(0, 20);
        i_req[1] = 1'b1;
        exp_q.push_back(1);
        w1 = next_ptr(model_ptr[1]); model_ptr[1] = w1;
        watch(2, 2 * PASS_LEN + 30);
        checks++;
        if (wto || ack_ch.size() != 2 || ack_ch[0] != 0 || ack_ch[1] != 1) begin
            errors++; $display("FAIL late_order acks %0d want ch0 then ch1", ack_ch.size());
        end
        checks++;
        if (ack_cyc.size() < 2 || res_cyc.size() < 1 || ack_cyc[1] != res_cyc[0] + 2) begin
            errors++; $display("FAIL late_gap ch1 ack not 2 cycles after ch0 result");
        end
        checks++;
        if (wr_addr.size() != 2 || wr_addr[0] != w0 || wr_addr[1] != w1) begin
            errors++; $display("FAIL late_wr got %0d writes want %0d %0d", wr_addr.size(), w0, w1);
        end
        for (int i = 0; i < res_ch.size(); i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_unexpected result ch %0d", res_ch[i]);
            end else begin
                e = exp_q.pop_front();
                if (res_ch[i] != e) begin
                    errors++; $display("FAIL late_result%0d ch %0d want %0d", i, res_ch[i], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        bit hit;
        clear_logs();
        auto_drop = 1'b1;
        i_req = 3'b001;
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            watch(0, 1);
            if (cf_addr.size() == 31) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_timeout tap 30 never issued"); end
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got %h want 0", all_outs);
        end
        i_rst = 1'b0;
        for (int c = 0; c < CH; c++) model_ptr[c] = 0;
        exp_q.delete();
        clear_logs();
        watch(0, 10);
        checks++;
        if (res_ch.size() != 0 || mac_cyc.size() != 0) begin
            errors++; $display("FAIL mid_abandon results %0d mac %0d want 0 0", res_ch.size(), mac_cyc.size());
        end
        clear_logs();
        i_req = 3'b001;
        exp_q.push_back(0);
        model_ptr[0] = next_ptr(model_ptr[0]);
        watch(1, PASS_LEN + 20);
        checks++;
        if (wto || wr_addr.size() != 1 || wr_addr[0] != model_ptr[0]) begin
            errors++; $display("FAIL mid_next_wr got %0d want %0d",
                               (wr_addr.size() > 0) ? wr_addr[0] : -1, model_ptr[0]);
        end
        for (int i = 0; i < res_ch.size(); i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_unexpected result ch %0d", res_ch[i]);
            end else begin
                e = exp_q.pop_front();
                if (res_ch[i] != e) begin
                    errors++; $display("FAIL mid_result ch %0d want %0d", res_ch[i], e);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [CH-1:0] exp_ovr;
        int e;
`ifdef FIR_SCHED_OVERRUN_EN
        exp_ovr = 3'b010;
`else
        exp_ovr = 3'b000;
`endif
        reset_dut();
        clear_logs();
        auto_drop = 1'b1;
        i_req = 3'b011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        watch(0, 20);
        checks++;
        if (o_overrun !== '0) begin
            errors++; $display("FAIL ovr_early got %b want 000", o_overrun);
        end
        watch(2, 2 * PASS_LEN + 30);
        checks++;
        if (wto || o_overrun !== exp_ovr) begin
            errors++; $display("FAIL ovr_set got %b want %b", o_overrun, exp_ovr);
        end
        watch(0, 10);
        checks++;
        if (o_overrun !== exp_ovr) begin
            errors++; $display("FAIL ovr_sticky got %b want %b", o_overrun, exp_ovr);
        end
        for (int i = 0; i < res_ch.size(); i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_unexpected result ch %0d", res_ch[i]);
            end else begin
                e = exp_q.pop_front();
                if (res_ch[i] != e) begin
                    errors++; $display("FAIL ovr_result%0d ch %0d want %0d", i, res_ch[i], e);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pass();
        test_wrap();
        test_round_robin();
        test_late_request();
        test_reset_mid();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Multi-channel sequencer for the shared FIR MAC datapath: coefficient BRAM, per-channel circular delay-line BRAM, and the registered multiply/accumulate unit.
- Arbitrates round-robin between CH_COUNT sample requesters. For each granted channel it writes the new sample, then issues one tap read per cycle and drives MAC enable and clear.
- Signals when the accumulator holds the final dot product for that channel.
- Sits between the sample-rate synchroniser and the MAC/output registers.

Parameters:
- DATA_WIDTH, 16, sample width; informational only, no datapath in this block.
- TAP_COUNT, 65, taps per channel; also the delay-line depth per channel.
- CH_COUNT, 2, number of requesters (1..8).
- MEM_LATENCY, 2, cycles from o_mem_rden to valid BRAM data at the MAC inputs.
- MAC_LATENCY, 3, cycles from the last o_mac_en to a stable accumulator.
- MAX_WAIT, 256, overrun threshold in cycles (optional feature only).
- Derived: LEN = $clog2(TAP_COUNT); CHW = max(1, $clog2(CH_COUNT)).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_req  in  CH_COUNT  level request per channel: new sample pending
- o_ack  out  CH_COUNT  one-cycle one-hot pulse when a request is accepted
- o_busy  out  1  high from grant until o_result_valid inclusive
- o_ch  out  CHW  channel being processed; steers the sample mux and delay-line bank
- o_dl_wren  out  1  delay-line write strobe (new sample)
- o_dl_wr_addr  out  LEN  write address within the channel bank
- o_mem_rden  out  1  read strobe for the delay line and coefficient BRAM
- o_dl_rd_addr  out  LEN  delay-line read address
- o_coeff_addr  out  LEN  coefficient address (tap index k)
- o_acc_clr  out  1  accumulator clear pulse
- o_mac_en  out  1  MAC input capture enable
- o_result_valid  out  1  one-cycle pulse: accumulator final for o_result_ch
- o_result_ch  out  CHW  channel of the finished result
- o_overrun  out  CH_COUNT  sticky overrun flags (optional feature)

Behaviour:
- **Reset** (i_rst sampled high): all outputs 0, state IDLE, wr_ptr[c] = 0 for every channel, priority pointer = channel 0. A reset during an active pass abandons it with no o_result_valid.
- **IDLE:** if any i_req is set, go to ARB; otherwise stay.
- **ARB (1 cycle):** select the first requesting channel at or after the priority pointer (round-robin). Pulse o_ack[c], latch o_ch = c, set o_busy. Move the priority pointer to (c+1) mod CH_COUNT.
  - Requesters must drop i_req the cycle after o_ack.
  - An i_req still high in IDLE/ARB is treated as a new sample.
  - Requests arriving during a pass are held, not lost.
- **WRITE (1 cycle):**
  - wr_ptr[c] = (wr_ptr[c]==0) ? TAP_COUNT-1 : wr_ptr[c]-1.
  - o_dl_wren = 1, o_dl_wr_addr = new wr_ptr.
  - o_acc_clr = 1.
- **ISSUE (TAP_COUNT cycles, k = 0..TAP_COUNT-1):**
  - o_mem_rden = 1, o_coeff_addr = k.
  - o_dl_rd_addr = (wr_ptr + k) mod TAP_COUNT, with no wrap overflow past TAP_COUNT-1.
  - Tap 0 reads the sample written in WRITE. Write-then-read of the same address is separated by one cycle.
- **o_mac_en** is o_mem_rden delayed by exactly MEM_LATENCY cycles through a shift register, giving TAP_COUNT consecutive enables.
- **DRAIN (MEM_LATENCY + MAC_LATENCY cycles):** counter only.
- **DONE (1 cycle):** o_result_valid = 1, o_result_ch = c; o_busy drops the next cycle; return to IDLE.
- **Throughput:**
  - The pass length grant→valid is TAP_COUNT + MEM_LATENCY + MAC_LATENCY + 2 cycles; with defaults that is 72.
  - The next ARB happens at the earliest 2 cycles after DONE: IDLE, then ARB.
- **Fairness:** with all requests held high, grants are strictly round-robin 0,1,…,CH_COUNT-1,0,…
- **Outputs:** every output except o_result_ch and o_ch is registered and strobe-style. o_ch and o_result_ch hold their value until the next grant.

Optional Feature:
- Macro: FIR_SCHED_OVERRUN_EN.
- **Defined:** per-channel wait counter counts cycles with i_req[c] high and no o_ack[c]. It clears on o_ack[c] and saturates. Reaching MAX_WAIT sets o_overrun[c], which stays set until i_rst. Scheduling is unaffected.
- **Undefined:** no counters; o_overrun is tied to 0.

Test Plan:
- **Single pass:** reset, pulse i_req[0] 1 cycle → o_ack[0] once; o_dl_wr_addr = 64; o_coeff_addr 0..64; o_dl_rd_addr 64,0,1..63; exactly 65 o_mac_en; o_result_valid 72 cycles after o_ack with o_result_ch = 0.
- **Wrap-around:** 66 consecutive ch0 passes → write addresses 64,63,…,0,64; first read of every pass equals its write address; never exceeds 64.
- **Round-robin:** CH_COUNT = 3, all i_req held high → ack order 0,1,2,0,1,2; no channel granted twice in a row while others request.
- **Simultaneous/late request:** i_req[1] rises mid-pass of ch0 → held; o_ack[1] exactly 2 cycles after ch0 o_result_valid.
- **Reset mid-operation:** i_rst at tap 30 → next cycle all outputs 0, no o_result_valid; the following pass writes address 64 again.
- **Overrun:** with FIR_SCHED_OVERRUN_EN, MAX_WAIT = 50, hold i_req[1] during a ch0 pass → o_overrun[1] set and sticky. Without the macro, o_overrun stays 0.
